// File: rtl/shift_serializer.sv
// shift_serializer
//   Parallel-in, serial-out transmitter feeding the serial-in shift registers.
//   A WIDTH-bit word is taken through a valid/ready load handshake and sent one
//   bit per clock, LSB-first or MSB-first. A per-bit ser_valid strobe marks
//   each bit. done pulses for one cycle after the last bit. hold freezes
//   shifting mid-word.
//
// Ports
//   clk         rising-edge clock
//   clr         synchronous active-high reset, overrides every other input
//   load_valid  data_in / msb_first offered for loading
//   load_ready  block can accept a word (IDLE only)
//   data_in     parallel word to transmit
//   msb_first   1 = MSB first, 0 = LSB first; sampled at load only
//   hold        1 = no bit advances this cycle
//   ser_out     current serial bit (0 outside SHIFT)
//   ser_valid   ser_out carries a valid bit this cycle
//   busy        high in SHIFT and DONE
//   done        one-cycle pulse after the last bit
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for load_valid; load_ready high
// SHIFT | sending bits; cnt holds the number of bits still to send
// DONE  | single cycle after the last bit; done high, then back to IDLE

module shift_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             msb_first,
  input  logic             hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             dir, dir_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      sreg  <= '0;
      dir   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      dir   <= dir_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    dir_nxt   = dir;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (load_valid) begin
          sreg_nxt  = data_in;
          dir_nxt   = msb_first;
          cnt_nxt   = CW'(WIDTH);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          // The outgoing bit always sits at the end selected by dir, so
          // shifting toward that end brings the next bit into position.
          if (dir)
            sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
          else
            sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
          cnt_nxt = cnt - CW'(1);
          // Terminal count: the bit on the wire now is the last one.
          if (cnt == CW'(1))
            state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  // hold is the only input with a direct path to an output.
  assign ser_valid  = (state == SHIFT) && !hold;
  assign ser_out    = (state == SHIFT) ? (dir ? sreg[WIDTH-1] : sreg[0]) : 1'b0;

endmodule

// File: tb/tb_shift_serializer.sv
module tb_shift_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] data_in;
  logic         msb_first;
  logic         hold;
  logic         ser_out;
  logic         ser_valid;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  shift_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .clr        (clr),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .data_in    (data_in),
    .msb_first  (msb_first),
    .hold       (hold),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the i-th bit on the wire for a word and direction.
  function automatic logic ref_bit(input logic [W-1:0] word, input logic msb, input int i);
    int idx;
    idx = msb ? (W - 1 - i) : i;
    return word[idx];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".load_ready"}, 32'(load_ready), 32'd1);
    check({tag, ".busy"},       32'(busy),       32'd0);
    check({tag, ".done"},       32'(done),       32'd0);
    check({tag, ".ser_valid"},  32'(ser_valid),  32'd0);
    check({tag, ".ser_out"},    32'(ser_out),    32'd0);
  endtask

  // Entered and left #1 after an edge, in an IDLE cycle.
  task automatic run_word(input string tag, input logic [W-1:0] word, input logic msb,
                          input int hold_at, input int hold_len, input bit rand_hold,
                          input bit busy_load, input logic [W-1:0] busy_data);
    int  i;
    int  cyc;
    int  dhold;
    int  exp_done_cyc;
    logic h;
    load_valid = 1'b1;
    data_in    = word;
    msb_first  = msb;
    hold       = 1'($urandom_range(0, 1));
    #1;
    check_idle({tag, ".idle"});
    @(posedge clk); #1;
    load_valid = busy_load;
    data_in    = busy_load ? busy_data : W'($urandom);
    msb_first  = busy_load ? 1'b0 : 1'($urandom_range(0, 1));
    i = 0; cyc = 0; dhold = 0; exp_done_cyc = W;
    while (i < W && cyc < 200) begin
      if (i == hold_at && dhold < hold_len) begin
        h = 1'b1;
        dhold++;
      end else if (rand_hold && cyc < 100) begin
        h = ($urandom_range(0, 3) == 0);
      end else begin
        h = 1'b0;
      end
      if (h) exp_done_cyc++;
      hold = h;
      #1;
      check({tag, ".busy"},       32'(busy),       32'd1);
      check({tag, ".load_ready"}, 32'(load_ready), 32'd0);
      check({tag, ".done"},       32'(done),       32'd0);
      check({tag, ".ser_valid"},  32'(ser_valid),  32'(!h));
      check({tag, ".ser_out"},    32'(ser_out),    32'(ref_bit(word, msb, i)));
      if (!h) i++;
      cyc++;
      @(posedge clk); #1;
      if (!busy_load) data_in = W'($urandom);
    end
    check({tag, ".bits_sent"},   32'(i),   32'(W));
    check({tag, ".done_cycle"},  32'(cyc), 32'(exp_done_cyc));
    hold = 1'($urandom_range(0, 1));
    #1;
    check({tag, ".done_pulse"}, 32'(done),       32'd1);
    check({tag, ".done_busy"},  32'(busy),       32'd1);
    check({tag, ".done_sv"},    32'(ser_valid),  32'd0);
    check({tag, ".done_so"},    32'(ser_out),    32'd0);
    check({tag, ".done_lr"},    32'(load_ready), 32'd0);
    @(posedge clk); #1;
    hold = 1'b0;
  endtask

  initial begin
    clr        = 1'b1;
    load_valid = 1'b1;
    data_in    = 4'b1011;
    msb_first  = 1'b0;
    hold       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr        = 1'b0;
    load_valid = 1'b0;
    #1;
    check_idle("reset");
    @(posedge clk); #1;
    check_idle("reset_no_accept");

    run_word("lsb_1011", 4'b1011, 1'b0, -1, 0, 1'b0, 1'b0, 4'b0000);
    run_word("msb_1011", 4'b1011, 1'b1, -1, 0, 1'b0, 1'b0, 4'b0000);
    run_word("hold_1011", 4'b1011, 1'b0, 2, 3, 1'b0, 1'b0, 4'b0000);
    run_word("busy_load", 4'b1011, 1'b0, -1, 0, 1'b0, 1'b1, 4'b0110);
    // load_valid stayed high with 0110 into IDLE: accepted at the next edge.
    #1;
    check("busy_load.idle_ready", 32'(load_ready), 32'd1);
    run_word("after_busy", 4'b0110, 1'b0, -1, 0, 1'b0, 1'b0, 4'b0000);

    // Reset mid-word after two bits have been sent.
    load_valid = 1'b1;
    data_in    = 4'b1011;
    msb_first  = 1'b0;
    @(posedge clk); #1;
    load_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("midclr.bit_sv", 32'(ser_valid), 32'd1);
      check("midclr.bit_so", 32'(ser_out), 32'(ref_bit(4'b1011, 1'b0, k)));
      @(posedge clk); #1;
    end
    clr        = 1'b1;
    load_valid = 1'b1;
    @(posedge clk); #1;
    clr        = 1'b0;
    load_valid = 1'b0;
    #1;
    check_idle("midclr.after");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("midclr.no_done", 32'(done), 32'd0);
      check("midclr.no_busy", 32'(busy), 32'd0);
    end
    run_word("after_clr", 4'b0001, 1'b0, -1, 0, 1'b0, 1'b0, 4'b0000);

    for (int n = 0; n < 20; n++) begin
      run_word("rand", W'($urandom), 1'($urandom_range(0, 1)), -1, 0, 1'b1, 1'b0, 4'b0000);
    end

    #1;
    check_idle("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
